sdcard_cmd_responder: RTL and testbench

//  Card-side endpoint of the SD CMD line, the counterpart of the host controller's command path.
//  - Deserialises 48-bit host command frames and checks framing and CRC7.
//  - Presents each good command to card logic, accepts a response over a valid/ready handshake,
//    and serialises a 48-bit R1/R3/R6/R7-style response after NCR bit times.
//  - Used as the synthesizable card model in the controller bench and in FPGA loopback builds.

---
 rtl/sdcard_cmd_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_sdcard_cmd_responder.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdcard_cmd_responder.sv
// sdcard_cmd_responder
//   Card-side endpoint of the SD CMD line. Deserialises 48-bit host command
//   frames, checks framing (and optionally CRC7), hands good commands to card
//   logic, accepts a response over a valid/ready handshake and serialises a
//   48-bit response NCR bit times after the command end bit.
//
//   Build option: define SDCARD_CMD_CRC_CHK_EN to check the received CRC7.
//   Without it the received CRC field is ignored and cmd_crc_err_o stays 0.
//   Response CRC7 generation is always present.
//
// Ports
//   PCLK_i, PRESET_i  : clock, asynchronous active-high reset
//   bit_en_i          : one-cycle strobe per SD clock edge; CMD sampled/driven only then
//   cmd_i             : sampled CMD line
//   cmd_o, cmd_oe_o   : CMD drive value and output enable
//   cmd_valid_o       : pulse, good command received (index/arg valid from that cycle)
//   cmd_index_o/arg_o : last good command, held until the next one
//   cmd_crc_err_o     : pulse, CRC7 mismatch
//   cmd_frame_err_o   : pulse, transmission bit or end bit not 1
//   rsp_valid_i/ready_o, rsp_none_i, rsp_no_crc_i, rsp_index_i, rsp_arg_i : response handshake
//   busy_o            : responder not idle

module sdcard_cmd_responder #(
    parameter int NCR         = 2,
    parameter int RSP_TIMEOUT = 64
) (
    input  logic        PCLK_i,
    input  logic        PRESET_i,
    input  logic        bit_en_i,
    input  logic        cmd_i,
    output logic        cmd_o,
    output logic        cmd_oe_o,
    output logic        cmd_valid_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic        cmd_crc_err_o,
    output logic        cmd_frame_err_o,
    input  logic        rsp_valid_i,
    output logic        rsp_ready_o,
    input  logic        rsp_none_i,
    input  logic        rsp_no_crc_i,
    input  logic [5:0]  rsp_index_i,
    input  logic [31:0] rsp_arg_i,
    output logic        busy_o
);

`ifdef SDCARD_CMD_CRC_CHK_EN
    localparam bit CRC_CHK = 1'b1;
`else
    localparam bit CRC_CHK = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RX, CHECK, WAIT_RSP, TX} state_t;

    state_t      state;
    state_t      next_state;

    logic [5:0]  rx_cnt;
    logic [46:0] rx_sr;
    logic [7:0]  ncnt;
    logic        rsp_latched;
    logic [47:0] tx_sr;
    logic [5:0]  tx_cnt;

    logic        frame_bad;
    logic        crc_bad;
    logic        handshake;
    logic        start_tx;
    logic        timed_out;
    logic [6:0]  rx_crc;
    logic [6:0]  rsp_crc;
    logic [47:0] rsp_frame;

    // CRC7, polynomial x^7 + x^3 + 1, initial value 0, MSB first.
    function automatic logic [6:0] crc7_calc(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) begin
                crc = crc ^ 7'h09;
            end
        end
        return crc;
    endfunction

    // rx_sr holds the 47 bits after the start bit, so rx_sr[46] is the
    // transmission bit and rx_sr[0] the end bit.
    assign rx_crc    = crc7_calc({1'b0, rx_sr[46:8]});
    assign frame_bad = !rx_sr[46] || !rx_sr[0];
    assign crc_bad   = CRC_CHK && (rx_crc != rx_sr[7:1]);

    // Ready drops once a response has been latched so a second offer cannot
    // overwrite the frame waiting for the NCR gap.
    assign rsp_ready_o = (state == WAIT_RSP) && !rsp_latched;
    assign handshake   = rsp_ready_o && rsp_valid_i;
    assign busy_o      = (state != IDLE);

    assign rsp_crc   = rsp_no_crc_i ? 7'h7F : crc7_calc({2'b00, rsp_index_i, rsp_arg_i});
    assign rsp_frame = {2'b00, rsp_index_i, rsp_arg_i, rsp_crc, 1'b1};

    // The start bit goes out on the bit strobe that brings the count of bit
    // times since the end bit up to NCR, hence the +1 on the current count.
    assign start_tx  = (state == WAIT_RSP) && rsp_latched && bit_en_i &&
                       ((int'(ncnt) + 1) >= NCR);
    assign timed_out = !rsp_latched && !handshake && (int'(ncnt) >= RSP_TIMEOUT);

    // State register.
    always_ff @(posedge PCLK_i or posedge PRESET_i) begin
        if (PRESET_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bit_en_i && !cmd_i) begin
                    next_state = RX;
                end
            end
            RX: begin
                if (bit_en_i && (rx_cnt == 6'd0)) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (frame_bad || crc_bad) begin
                    next_state = IDLE;
                end else begin
                    next_state = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (handshake && rsp_none_i) begin
                    next_state = IDLE;
                end else if (start_tx) begin
                    next_state = TX;
                end else if (timed_out) begin
                    next_state = IDLE;
                end
            end
            TX: begin
                if (bit_en_i && (tx_cnt == 6'd0)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: shift registers, counters, held command fields, status pulses
    // and the registered CMD drive.
    always_ff @(posedge PCLK_i or posedge PRESET_i) begin
        if (PRESET_i) begin
            rx_cnt          <= '0;
            rx_sr           <= '0;
            ncnt            <= '0;
            rsp_latched     <= 1'b0;
            tx_sr           <= '0;
            tx_cnt          <= '0;
            cmd_o           <= 1'b1;
            cmd_oe_o        <= 1'b0;
            cmd_valid_o     <= 1'b0;
            cmd_crc_err_o   <= 1'b0;
            cmd_frame_err_o <= 1'b0;
            cmd_index_o     <= '0;
            cmd_arg_o       <= '0;
        end else begin
            cmd_valid_o     <= 1'b0;
            cmd_crc_err_o   <= 1'b0;
            cmd_frame_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bit_en_i && !cmd_i) begin
                        rx_cnt <= 6'd46;
                    end
                end
                RX: begin
                    if (bit_en_i) begin
                        rx_sr <= {rx_sr[45:0], cmd_i};
                        if (rx_cnt != 6'd0) begin
                            rx_cnt <= rx_cnt - 6'd1;
                        end
                    end
                end
                CHECK: begin
                    ncnt        <= '0;
                    rsp_latched <= 1'b0;
                    if (frame_bad) begin
                        cmd_frame_err_o <= 1'b1;
                    end else if (crc_bad) begin
                        cmd_crc_err_o <= 1'b1;
                    end else begin
                        cmd_index_o <= rx_sr[45:40];
                        cmd_arg_o   <= rx_sr[39:8];
                        cmd_valid_o <= 1'b1;
                    end
                end
                WAIT_RSP: begin
                    if (bit_en_i && (ncnt != 8'hFF)) begin
                        ncnt <= ncnt + 8'd1;
                    end
                    if (handshake && !rsp_none_i) begin
                        tx_sr       <= rsp_frame;
                        rsp_latched <= 1'b1;
                    end
                    if (start_tx) begin
                        cmd_oe_o <= 1'b1;
                        cmd_o    <= tx_sr[47];
                        tx_sr    <= {tx_sr[46:0], 1'b0};
                        tx_cnt   <= 6'd47;
                    end
                end
                TX: begin
                    if (bit_en_i) begin
                        if (tx_cnt == 6'd0) begin
                            cmd_oe_o <= 1'b0;
                            cmd_o    <= 1'b1;
                        end else begin
                            cmd_o  <= tx_sr[47];
                            tx_sr  <= {tx_sr[46:0], 1'b0};
                            tx_cnt <= tx_cnt - 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdcard_cmd_responder.sv
// tb_sdcard_cmd_responder
//   Drives host command frames into sdcard_cmd_responder, plays card logic on
//   the response handshake, and checks every status pulse and serialised
//   response against an expected-event queue filled by the stimulus.

module tb_sdcard_cmd_responder;

    localparam int NCR         = 2;
    localparam int RSP_TIMEOUT = 64;

    localparam int K_CMD = 0;
    localparam int K_CRC = 1;
    localparam int K_FRM = 2;
    localparam int K_RSP = 3;

    typedef struct {
        int          kind;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [47:0] rsp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_en;
    logic        cmd_i;
    logic        cmd_o;
    logic        cmd_oe;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        crc_err;
    logic        frame_err;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_none;
    logic        rsp_no_crc;
    logic [5:0]  rsp_index;
    logic [31:0] rsp_arg;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    bit   bitEnRun = 1'b0;
    int   divCnt = 0;
    exp_t expQ[$];

    sdcard_cmd_responder #(.NCR(NCR), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
        .PCLK_i         (clk),
        .PRESET_i       (rst),
        .bit_en_i       (bit_en),
        .cmd_i          (cmd_i),
        .cmd_o          (cmd_o),
        .cmd_oe_o       (cmd_oe),
        .cmd_valid_o    (cmd_valid),
        .cmd_index_o    (cmd_index),
        .cmd_arg_o      (cmd_arg),
        .cmd_crc_err_o  (crc_err),
        .cmd_frame_err_o(frame_err),
        .rsp_valid_i    (rsp_valid),
        .rsp_ready_o    (rsp_ready),
        .rsp_none_i     (rsp_none),
        .rsp_no_crc_i   (rsp_no_crc),
        .rsp_index_i    (rsp_index),
        .rsp_arg_i      (rsp_arg),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    // Bit strobe: one cycle in four, updated just after the rising edge so it
    // is stable when the design samples it.
    initial begin
        bit_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            divCnt = divCnt + 1;
            bit_en = bitEnRun && ((divCnt % 4) == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushExp(input int kind, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [47:0] rsp);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.arg  = arg;
        e.rsp  = rsp;
        expQ.push_back(e);
    endtask

    task automatic popExp(input int kind, input string name, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{default: '0};
        if (expQ.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL %s unexpected event kind=%0d, nothing expected at %0t", name, kind, $time);
        end else begin
            checkOutput({name, "_kind"}, 48'(kind), 48'(expQ[0].kind));
            if (expQ[0].kind == kind) begin
                e  = expQ.pop_front();
                ok = 1'b1;
            end
        end
    endtask

    // Monitor: samples away from the rising edge and pops the expected queue
    // for every pulse and for every completed 48-bit response.
    initial begin
        bit          en;
        bit          ok;
        exp_t        e;
        int          rspBits = 0;
        int          bitsSinceValid = 0;
        logic [47:0] rspShift = '0;
        forever begin
            @(posedge clk);
            en = bit_en;
            @(negedge clk);
            if (rst) begin
                rspBits = 0;
                if ((expQ.size() > 0) && (expQ[0].kind == K_RSP)) begin
                    void'(expQ.pop_front());
                end
                continue;
            end
            if (cmd_valid) begin
                bitsSinceValid = 0;
                popExp(K_CMD, "cmd_valid", e, ok);
                if (ok) begin
                    checkOutput("cmd_index", 48'(cmd_index), 48'(e.idx));
                    checkOutput("cmd_arg", 48'(cmd_arg), 48'(e.arg));
                end
            end
            if (crc_err) begin
                popExp(K_CRC, "crc_err", e, ok);
            end
            if (frame_err) begin
                popExp(K_FRM, "frame_err", e, ok);
                checkOutput("frame_err_idle", 48'(busy), 48'd0);
            end
            if (en) begin
                bitsSinceValid = bitsSinceValid + 1;
            end
            if (en && cmd_oe) begin
                if (rspBits == 0) begin
                    checkOutput("ncr_latency", 48'(bitsSinceValid), 48'(NCR));
                end
                rspShift = {rspShift[46:0], cmd_o};
                rspBits  = rspBits + 1;
                if (rspBits == 48) begin
                    rspBits = 0;
                    popExp(K_RSP, "response", e, ok);
                    if (ok) begin
                        checkOutput("response_bits", rspShift, e.rsp);
                    end
                end
            end
        end
    end

    task automatic waitBitEn();
        do @(posedge clk); while (!bit_en);
    endtask

    // Sends one host frame MSB first; optionally stalls the bit strobe for
    // 100 cycles before bit number stallAt (counted from the start bit).
    task automatic applyStimulus(input logic [47:0] frame, input int stallAt);
        logic [47:0] f;
        f = frame;
        for (int i = 47; i >= 0; i--) begin
            if ((47 - i) == stallAt) begin
                @(negedge clk);
                bitEnRun = 1'b0;
                repeat (100) @(negedge clk);
                bitEnRun = 1'b1;
            end
            @(negedge clk);
            cmd_i = f[i];
            waitBitEn();
        end
        @(negedge clk);
        cmd_i = 1'b1;
    endtask

    task automatic waitReady(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rsp_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL wait_ready timed out actual=0 expected=1");
        end
    endtask

    task automatic respond(input bit none, input bit noCrc, input logic [5:0] idx, input logic [31:0] arg);
        bit ok;
        waitReady(ok);
        if (ok) begin
            rsp_valid  = 1'b1;
            rsp_none   = none;
            rsp_no_crc = noCrc;
            rsp_index  = idx;
            rsp_arg    = arg;
            @(negedge clk);
            rsp_valid  = 1'b0;
            rsp_none   = 1'b0;
            rsp_no_crc = 1'b0;
        end
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL wait_idle timed out actual=busy expected=idle");
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int  bitCount;
        bit  ok;
        rst        = 1'b1;
        cmd_i      = 1'b1;
        rsp_valid  = 1'b0;
        rsp_none   = 1'b0;
        rsp_no_crc = 1'b0;
        rsp_index  = '0;
        rsp_arg    = '0;
        repeat (4) @(negedge clk);
        checkOutput("reset_cmd_o", 48'(cmd_o), 48'd1);
        checkOutput("reset_cmd_oe", 48'(cmd_oe), 48'd0);
        checkOutput("reset_ready", 48'(rsp_ready), 48'd0);
        checkOutput("reset_busy", 48'(busy), 48'd0);
        checkOutput("reset_index_arg", {10'd0, cmd_index, cmd_arg}, 48'd0);
        checkOutput("reset_pulses", {45'd0, cmd_valid, crc_err, frame_err}, 48'd0);
        rst      = 1'b0;
        bitEnRun = 1'b1;
        repeat (8) @(negedge clk);

        // CMD0, no response needed.
        pushExp(K_CMD, 6'd0, 32'h0, 48'h0);
        applyStimulus(48'h40_0000_0000_95, -1);
        respond(1'b1, 1'b0, 6'd0, 32'd0);
        waitIdle();

        // CMD55 with an R1 response carrying a generated CRC7.
        pushExp(K_CMD, 6'h37, 32'h0, 48'h0);
        pushExp(K_RSP, 6'h0, 32'h0, 48'h37_0000_0120_83);
        applyStimulus(48'h77_0000_0000_65, -1);
        respond(1'b0, 1'b0, 6'h37, 32'h0000_0120);
        waitIdle();

        // CMD55 answered with an R3-style response: CRC field forced to 7F.
        pushExp(K_CMD, 6'h37, 32'h0, 48'h0);
        pushExp(K_RSP, 6'h0, 32'h0, 48'h3F_80FF_8000_FF);
        applyStimulus(48'h77_0000_0000_65, -1);
        respond(1'b0, 1'b1, 6'h3F, 32'h80FF_8000);
        waitIdle();

        // CMD8 with a corrupted CRC byte.
`ifdef SDCARD_CMD_CRC_CHK_EN
        pushExp(K_CRC, 6'h0, 32'h0, 48'h0);
        applyStimulus(48'h48_0000_01AA_89, -1);
`else
        pushExp(K_CMD, 6'h08, 32'h0000_01AA, 48'h0);
        applyStimulus(48'h48_0000_01AA_89, -1);
        respond(1'b1, 1'b0, 6'd0, 32'd0);
`endif
        waitIdle();

        // End bit 0, then transmission bit 0 (CRC also wrong: framing wins).
        pushExp(K_FRM, 6'h0, 32'h0, 48'h0);
        applyStimulus(48'h40_0000_0000_94, -1);
        waitIdle();
        pushExp(K_FRM, 6'h0, 32'h0, 48'h0);
        applyStimulus(48'h00_0000_0000_95, -1);
        waitIdle();

        // CMD8 with the bit strobe stalled for 100 cycles mid-frame.
        pushExp(K_CMD, 6'h08, 32'h0000_01AA, 48'h0);
        applyStimulus(48'h48_0000_01AA_87, 20);
        respond(1'b1, 1'b0, 6'd0, 32'd0);
        waitIdle();

        // No handshake: ready must stay up for exactly RSP_TIMEOUT bit times.
        pushExp(K_CMD, 6'h37, 32'h0, 48'h0);
        applyStimulus(48'h77_0000_0000_65, -1);
        waitReady(ok);
        bitCount = 0;
        if (ok) begin
            ok = 1'b0;
            for (int c = 0; c < 2000; c++) begin
                if (!rsp_ready) begin
                    ok = 1'b1;
                    break;
                end
                if (bit_en) begin
                    bitCount = bitCount + 1;
                end
                @(negedge clk);
            end
            checkOutput("timeout_ready_dropped", 48'(ok), 48'd1);
            checkOutput("timeout_bit_times", 48'(bitCount), 48'(RSP_TIMEOUT));
        end
        waitIdle();
        checkOutput("timeout_cmd_oe", 48'(cmd_oe), 48'd0);

        // Reset in the middle of a response.
        pushExp(K_CMD, 6'h37, 32'h0, 48'h0);
        pushExp(K_RSP, 6'h0, 32'h0, 48'h37_0000_0120_83);
        applyStimulus(48'h77_0000_0000_65, -1);
        respond(1'b0, 1'b0, 6'h37, 32'h0000_0120);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (cmd_oe) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("tx_started", 48'(ok), 48'd1);
        repeat (19) waitBitEn();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("reset_tx_cmd_oe", 48'(cmd_oe), 48'd0);
        checkOutput("reset_tx_cmd_o", 48'(cmd_o), 48'd1);
        checkOutput("reset_tx_busy", 48'(busy), 48'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Recovery after reset.
        pushExp(K_CMD, 6'd0, 32'h0, 48'h0);
        applyStimulus(48'h40_0000_0000_95, -1);
        respond(1'b1, 1'b0, 6'd0, 32'd0);
        waitIdle();

        checkOutput("expected_queue_empty", 48'(expQ.size()), 48'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
